// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bank
// Description : Register bank behind an SPI slave byte interface. The first
//               byte of a frame is a command: bit 7 selects read (1) or
//               write (0), and bits [2:0] give the start address. The
//               following bytes are written to, or read from, consecutive
//               addresses. The address wraps from 7 to 0.
//               Address map: 0..5 are read/write registers, 6 is the live
//               status_in value (read-only), 7 is ID_VALUE (read-only).
// Ports       : clk, rst_n        - clock, async active-low reset
//               ssel              - SPI chip select, active-low
//               byteReceived      - one-clk strobe, receivedData valid
//               receivedData[7:0] - byte shifted in from MOSI
//               dataNeeded        - slave loading next TX byte (observed only)
//               dataToSend[7:0]   - next byte to shift out on MISO
//               status_in[7:0]    - live status, readable at address 6
//               regs_flat[47:0]   - registers 0..5, reg n at [8n+7:8n]
//               wr_pulse          - one-clk pulse after each accepted write
//               wr_addr[2:0]      - address of the last accepted write
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bank #(
   parameter logic [7:0]  ID_VALUE  = 8'hA5,
   parameter logic [47:0] RST_VALUE = 48'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ssel,
   input  logic        byteReceived,
   input  logic [7:0]  receivedData,
   input  logic        dataNeeded,
   output logic [7:0]  dataToSend,
   input  logic [7:0]  status_in,
   output logic [47:0] regs_flat,
   output logic        wr_pulse,
   output logic [2:0]  wr_addr
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_CMD   = 2'd1;
   localparam logic [1:0] c_WDATA = 2'd2;
   localparam logic [1:0] c_RDATA = 2'd3;
   localparam logic [2:0] c_LAST_RW = 3'd5;

   logic [1:0]  r_state;
   logic [1:0]  w_state_next;
   logic [2:0]  r_ptr;
   logic [2:0]  w_ptr_next;
   logic [7:0]  r_dts;
   logic [7:0]  w_dts_next;
   logic [47:0] r_regs;
   logic        r_wr_pulse;
   logic [2:0]  r_wr_addr;
   logic        w_wr_en;
   logic        w_unused;

   // dataNeeded carries no timing information this block needs: dataToSend
   // is already stable one clk after byteReceived.
   assign w_unused = dataNeeded;

   function automatic logic [7:0] read_mux(input logic [2:0]  addr,
                                           input logic [47:0] regs,
                                           input logic [7:0]  status);
      logic [7:0] v;
      case (addr)
         3'd6:    v = status;
         3'd7:    v = ID_VALUE;
         default: v = regs[{addr, 3'b000} +: 8];
      endcase
      return v;
   endfunction

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_IDLE;
      else        r_state <= w_state_next;
   end

   // ---------------- next-state logic ----------------
   // A deasserted chip select wins over everything, including a byte strobe
   // on the same clk, so an aborted frame never commits a partial byte.
   always_comb begin
      w_state_next = r_state;
      if (ssel) begin
         w_state_next = c_IDLE;
      end else begin
         case (r_state)
            c_IDLE:  w_state_next = c_CMD;
            c_CMD:   if (byteReceived)
                        w_state_next = receivedData[7] ? c_RDATA : c_WDATA;
            default: w_state_next = r_state;
         endcase
      end
   end

   // ---------------- output / datapath logic ----------------
   always_comb begin
      w_ptr_next = r_ptr;
      w_dts_next = r_dts;
      w_wr_en    = 1'b0;
      if (ssel) begin
         w_dts_next = 8'h00;
      end else begin
         case (r_state)
            c_IDLE: w_dts_next = 8'h00;
            c_CMD: begin
               if (byteReceived) begin
                  w_ptr_next = receivedData[2:0];
                  if (receivedData[7])
                     w_dts_next = read_mux(receivedData[2:0], r_regs, status_in);
               end
            end
            c_WDATA: begin
               if (byteReceived) begin
                  w_wr_en    = (r_ptr <= c_LAST_RW);
                  w_ptr_next = r_ptr + 3'd1;
               end
            end
            default: begin
               if (byteReceived) begin
                  w_ptr_next = r_ptr + 3'd1;
                  w_dts_next = read_mux(r_ptr + 3'd1, r_regs, status_in);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= 3'd0;
         r_dts      <= 8'h00;
         r_regs     <= RST_VALUE;
         r_wr_pulse <= 1'b0;
         r_wr_addr  <= 3'd0;
      end else begin
         r_ptr      <= w_ptr_next;
         r_dts      <= w_dts_next;
         r_wr_pulse <= w_wr_en;
         if (w_wr_en) begin
            r_regs[{r_ptr, 3'b000} +: 8] <= receivedData;
            r_wr_addr                    <= r_ptr;
         end
      end
   end

   assign dataToSend = r_dts;
   assign regs_flat  = r_regs;
   assign wr_pulse   = r_wr_pulse;
   assign wr_addr    = r_wr_addr;

endmodule
`default_nettype wire

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter: ID_VALUE, default 8'hA5, constant returned on reads of address 7.
REQ-002 Parameter: RST_VALUE, default 48'h0, reset contents of registers 0..5, with reg0 in bits [7:0].
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ssel  input  1  SPI chip select, active-low, same line driven to the SPI slave.
REQ-006 byteReceived  input  1  one-clk pulse from the SPI slave: receivedData is valid.
REQ-007 receivedData  input  8  byte just shifted in, MSB first.
REQ-008 dataNeeded  input  1  high while the SPI slave is loading its next transmit byte.
REQ-009 dataToSend  output  8  next byte for the SPI slave to shift out on MISO.
REQ-010 status_in  input  8  live status value, read-only at address 6.
REQ-011 regs_flat  output  48  registers 0..5 concatenated, reg n in bits [8n+7:8n].
REQ-012 wr_pulse  output  1  one-clk pulse on every accepted register write.
REQ-013 wr_addr  output  3  address of the last accepted write; valid while wr_pulse is high.

Function
REQ-014 FSM states: IDLE, CMD, WDATA, RDATA; state, address pointer and dataToSend are registered.
REQ-015 IDLE: when ssel is low, go to CMD on the next clk; dataToSend = 8'h00.
REQ-016 CMD: on the first byteReceived of a frame, decode receivedData. Bit7=1 selects read, bit7=0 selects write. Bits[2:0] give the start address; bits[6:3] are ignored.
REQ-017 CMD with write: go to WDATA with ptr = cmd[2:0]; dataToSend stays 8'h00.
REQ-018 CMD with read: go to RDATA with ptr = cmd[2:0]; in the same clk edge, load dataToSend with the read value at cmd[2:0].
REQ-019 Read mux: addresses 0..5 return reg n, 6 returns status_in sampled at the load edge, 7 returns ID_VALUE.
REQ-020 WDATA: on each byteReceived, write receivedData to reg[ptr] if ptr <= 5. In that case assert wr_pulse for exactly 1 clk on the following cycle, with wr_addr = ptr.
REQ-021 WDATA: writes to ptr 6 or 7 are dropped with no wr_pulse; ptr still advances.
REQ-022 RDATA: on each byteReceived, set ptr = ptr+1 and load dataToSend with the read value at the new ptr on the same edge. Incoming MOSI bytes are ignored.
REQ-023 Address arithmetic: ptr is 3 bits and wraps 7 -> 0 in both WDATA and RDATA.
REQ-024 Latency: dataToSend is stable one clk after byteReceived. This is well before the next SCK rising edge, so it is valid throughout dataNeeded.
REQ-025 dataNeeded is used for observation only. The block never changes dataToSend except on the edges in REQ-018/REQ-022 and on return to IDLE.
REQ-026 ssel high in any state: go to IDLE on the next clk and clear dataToSend to 8'h00. A frame in progress is aborted; completed writes are kept and no partial write occurs.
REQ-027 byteReceived together with ssel rising on the same clk: ssel takes priority and the byte is discarded.
REQ-028 A frame consisting of a command byte only performs no write.
REQ-029 regs_flat is driven directly from the register flops with no combinational path from inputs.

Reset
REQ-030 While rst_n is low: state = IDLE, ptr = 0, dataToSend = 8'h00, wr_pulse = 0, wr_addr = 0, regs = RST_VALUE.
REQ-031 rst_n is asserted asynchronously and released synchronously to clk. Reset mid-frame restores all REQ-030 values; the FSM then waits in IDLE until ssel is seen low.

Verification
REQ-032 Write burst: ssel low, bytes 8'h02, 8'h11, 8'h22, 8'h33 -> reg2=11, reg3=22, reg4=33; three wr_pulse with wr_addr 2, 3, 4.
REQ-033 Read burst with wrap: preload reg0=8'h5A, status_in=8'hC3, cmd 8'h86, three dummy bytes -> MISO returns C3, A5, 5A.
REQ-034 Read-only protection: cmd 8'h05, data 8'hAA, 8'hBB, 8'hCC, 8'hDD -> reg5=AA; addresses 6 and 7 unchanged; reg0=DD; wr_pulse count 2.
REQ-035 Abort: cmd 8'h01, then ssel raised after 4 bits of the data byte -> reg1 unchanged, state IDLE, dataToSend=00.
REQ-036 Async reset mid read burst: rst_n low for 3 clk -> all outputs at reset values immediately; the next frame with cmd 8'h80 returns RST_VALUE[7:0].
REQ-037 Back-to-back frames with 1 clk of ssel high: the second frame decodes its first byte as a command.
